register_dump: RTL and testbench
================================

REGISTER_DUMP -- requirements
Module: register_dump

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0, first register index dumped (0..31).
REQ-002 SHALL have parameter LAST_REG, default 31, last register index dumped (FIRST_REG..31); FIRST_REG > LAST_REG SHALL be an elaboration error.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  request a dump; sampled only in IDLE.
REQ-006 SHALL have port RA  output  5  read address to one register-file read port.
REQ-007 SHALL have port RD  input  32  combinational read data for RA.
REQ-008 SHALL have port OUT_VALID  output  1  OUT_* word valid.
REQ-009 SHALL have port OUT_READY  input  1  sink accepts word.
REQ-010 SHALL have port OUT_DATA  output  32  dumped register value.
REQ-011 SHALL have port OUT_INDEX  output  5  register index of OUT_DATA.
REQ-012 SHALL have port OUT_LAST  output  1  final word of dump.
REQ-013 SHALL have port OUT_CSUM  output  1  word is checksum (REQ-030).
REQ-014 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse after final handshake.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, SEND, FIN.
REQ-017 IDLE: START=1 SHALL load idx<=FIRST_REG and go to FETCH; START=0 stays IDLE.
REQ-018 RA SHALL equal idx in every state (registered, never glitching mid-cycle).
REQ-019 FETCH: SHALL register OUT_DATA<=RD, OUT_INDEX<=idx, OUT_VALID<=1, OUT_LAST<=(idx==LAST_REG), go to SEND; latency START to first OUT_VALID = 2 cycles.
REQ-020 SEND: OUT_DATA, OUT_INDEX, OUT_LAST, OUT_CSUM SHALL hold stable while OUT_VALID=1 and OUT_READY=0, for any stall length.
REQ-021 SEND with OUT_READY=1: OUT_VALID<=0; idx==LAST_REG -> FIN, else idx<=idx+1 -> FETCH.
REQ-022 Throughput SHALL be one word per 2 cycles with OUT_READY held high.
REQ-023 FIN: DONE=1 for exactly one cycle, then IDLE; START in FIN SHALL be ignored.
REQ-024 START while BUSY=1 SHALL be ignored; no queuing.
REQ-025 Each word SHALL be the register value at its FETCH cycle; no snapshot coherence across words.
REQ-026 idx SHALL never increment past LAST_REG; no wrap to 0.
REQ-027 OUT_VALID SHALL never deassert without a handshake except via reset.

Reset
REQ-028 RESET_N=0 SHALL asynchronously force IDLE, idx=FIRST_REG, RA=FIRST_REG, OUT_DATA=0, OUT_INDEX=0, OUT_VALID=0, OUT_LAST=0, OUT_CSUM=0, BUSY=0, DONE=0, checksum=0.
REQ-029 Reset mid-dump SHALL abort with no further words; first edge after release with START=1 SHALL begin a fresh dump.

Configuration
REQ-030 With DUMP_CHECKSUM_EN defined: SHALL keep a 32-bit XOR of every handshaken register word (cleared on START accept); OUT_LAST SHALL NOT assert on register words; after the LAST_REG handshake the FSM SHALL pass through FETCH once more presenting OUT_DATA=checksum, OUT_INDEX=LAST_REG, OUT_CSUM=1, OUT_LAST=1, then FIN after its handshake.
REQ-031 Without DUMP_CHECKSUM_EN: no checksum logic; OUT_CSUM tied 0; OUT_LAST on LAST_REG word.

Verification
REQ-032 Default params, regs[i]=i*0x11111111 (wraps mod 2^32), OUT_READY=1, pulse START -> 32 words, indices 0..31 in order, matching data, OUT_LAST only on index 31, DONE pulse 1 cycle after last handshake.
REQ-033 FIRST_REG=3, LAST_REG=5, random OUT_READY stalls up to 7 cycles -> exactly 3 words (3,4,5), payload stable during every stall.
REQ-034 START pulsed again at word 10 and in FIN -> ignored; single 32-word dump.
REQ-035 RESET_N low while OUT_VALID=1 at index 7 -> all outputs 0 same cycle (async); new START -> dump restarts at index 0.
REQ-036 DUMP_CHECKSUM_EN, regs 1..31 = 0x1,0x2,...,0x1F, reg0=0 -> 33rd word OUT_DATA=0x00000000 (XOR 0..31), OUT_CSUM=1, OUT_LAST=1.
REQ-037 Register-file write to reg 20 (0xDEADBEEF) during dump at index 10 -> word 20 carries 0xDEADBEEF.

Source files
------------

// File: rtl/register_dump.sv
// register_dump: walks one register-file read port from FIRST_REG to LAST_REG and streams each
// value out over a valid/ready handshake. Define DUMP_CHECKSUM_EN to append an XOR checksum word.
module register_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  output logic [4:0]  RA,
  input  logic [31:0] RD,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_DATA,
  output logic [4:0]  OUT_INDEX,
  output logic        OUT_LAST,
  output logic        OUT_CSUM,
  output logic        BUSY,
  output logic        DONE
);
  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  if (FIRST_REG < 0 || LAST_REG > 31 || FIRST_REG > LAST_REG) begin : g_range_check
    $error("register_dump: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

  state_t      state, state_next;
  logic [4:0]  idx;
  logic        at_last;
  logic        send_final;
  logic        fetch_last;
  logic [31:0] fetch_data;

  assign at_last = (idx == LAST_IDX);
  // The read address is the registered index itself, so it only moves on a clock edge.
  assign RA = idx;

`ifdef DUMP_CHECKSUM_EN
  logic [31:0] checksum;
  logic        csum_phase;

  // csum_phase marks the extra FETCH/SEND pass that presents the checksum instead of RD.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      checksum   <= '0;
      csum_phase <= 1'b0;
      OUT_CSUM   <= 1'b0;
    end else begin
      if (state == IDLE && START) begin
        checksum   <= '0;
        csum_phase <= 1'b0;
      end else if (state == SEND && OUT_READY && !csum_phase) begin
        checksum <= checksum ^ OUT_DATA;
        if (at_last) csum_phase <= 1'b1;
      end
      if (state == FETCH) OUT_CSUM <= csum_phase;
    end
  end

  assign fetch_data = csum_phase ? checksum : RD;
  assign fetch_last = csum_phase;
  assign send_final = at_last && csum_phase;
`else
  assign OUT_CSUM   = 1'b0;
  assign fetch_data = RD;
  assign fetch_last = at_last;
  assign send_final = at_last;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    BUSY       = 1'b1;
    DONE       = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) state_next = FETCH;
      end
      FETCH: state_next = SEND;
      SEND: begin
        if (OUT_READY) state_next = send_final ? FIN : FETCH;
      end
      FIN: begin
        DONE       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx       <= FIRST_IDX;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_INDEX <= '0;
      OUT_LAST  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) idx <= FIRST_IDX;
        end
        FETCH: begin
          OUT_VALID <= 1'b1;
          OUT_DATA  <= fetch_data;
          OUT_INDEX <= idx;
          OUT_LAST  <= fetch_last;
        end
        SEND: begin
          // Payload stays frozen until the sink takes it; idx saturates at LAST_REG.
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            if (!at_last) idx <= idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump.sv
// Scoreboard bench for register_dump: full dump, ignored STARTs, stalls with a mid-dump register
// write, async reset mid-dump, and a narrow FIRST_REG=3..LAST_REG=5 instance with random stalls.
`timescale 1ns/1ps
module tb_register_dump;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start0, start1, rdy0, rdy1;
  logic [4:0]  ra0, ra1, idx0, idx1;
  logic [31:0] rd0, rd1, dat0, dat1;
  logic        vld0, vld1, last0, last1, csum0, csum1, busy0, busy1, done0, done1;
  logic [31:0] regs [32];
  logic [31:0] mregs [32];

  assign rd0 = regs[ra0];
  assign rd1 = regs[ra1];

  register_dump u0 (
    .CLK(clk), .RESET_N(rst_n), .START(start0), .RA(ra0), .RD(rd0),
    .OUT_VALID(vld0), .OUT_READY(rdy0), .OUT_DATA(dat0), .OUT_INDEX(idx0),
    .OUT_LAST(last0), .OUT_CSUM(csum0), .BUSY(busy0), .DONE(done0)
  );

  register_dump #(.FIRST_REG(3), .LAST_REG(5)) u1 (
    .CLK(clk), .RESET_N(rst_n), .START(start1), .RA(ra1), .RD(rd1),
    .OUT_VALID(vld1), .OUT_READY(rdy1), .OUT_DATA(dat1), .OUT_INDEX(idx1),
    .OUT_LAST(last1), .OUT_CSUM(csum1), .BUSY(busy1), .DONE(done1)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  index;
    logic        last;
    logic        csum;
  } word_t;

  word_t q0[$];
  word_t q1[$];
  int    checks = 0;
  int    errors = 0;
  int    hold_v [2];
  word_t held [2];
  int    done_chk [2];
  logic  mode0, mode1;
  int    c0, c1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream of one dump, built from the model register image mregs.
  task automatic push_dump(input int w, input int first, input int lst);
    logic [31:0] x;
    word_t e;
    x = '0;
    for (int i = first; i <= lst; i++) begin
      e.data  = mregs[i];
      e.index = 5'(i);
      e.csum  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      e.last  = 1'b0;
`else
      e.last  = (i == lst);
`endif
      x = x ^ mregs[i];
      if (w == 0) q0.push_back(e); else q1.push_back(e);
    end
`ifdef DUMP_CHECKSUM_EN
    e.data = x; e.index = 5'(lst); e.last = 1'b1; e.csum = 1'b1;
    if (w == 0) q0.push_back(e); else q1.push_back(e);
`endif
  endtask

  task automatic mon_step(input int w, input logic v, input logic r, input word_t o,
                          input logic d, input logic b);
    word_t e;
    if (done_chk[w] == 1) begin
      chk("done_pulse", 64'(d), 64'd1);
      done_chk[w] = 2;
    end else if (done_chk[w] == 2) begin
      chk("done_width", 64'(d), 64'd0);
      chk("busy_after_done", 64'(b), 64'd0);
      done_chk[w] = 0;
    end
    if (hold_v[w] != 0) begin
      chk("valid_held", 64'(v), 64'd1);
      chk("payload_stable", 64'(o), 64'(held[w]));
    end
    hold_v[w] = (v && !r) ? 1 : 0;
    held[w]   = o;
    if (v && r) begin
      if ((w == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: dut%0d gave index %0d data %h, none expected", w, o.index, o.data);
      end else begin
        e = (w == 0) ? q0.pop_front() : q1.pop_front();
        chk("word", 64'(o), 64'(e));
        if (e.last) done_chk[w] = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v[0] = 0; hold_v[1] = 0; done_chk[0] = 0; done_chk[1] = 0;
    end else begin
      mon_step(0, vld0, rdy0, {dat0, idx0, last0, csum0}, done0, busy0);
      mon_step(1, vld1, rdy1, {dat1, idx1, last1, csum1}, done1, busy1);
    end
  end

  // Ready driver: in stall mode, one ready cycle followed by 0..7 stalled cycles.
  initial begin
    rdy0 = 1'b1; rdy1 = 1'b1; c0 = 0; c1 = 0;
    forever begin
      @(posedge clk); #1;
      if (mode0 && c0 > 0) begin rdy0 = 1'b0; c0--; end
      else begin rdy0 = 1'b1; c0 = mode0 ? int'($urandom_range(0, 7)) : 0; end
      if (mode1 && c1 > 0) begin rdy1 = 1'b0; c1--; end
      else begin rdy1 = 1'b1; c1 = mode1 ? int'($urandom_range(0, 7)) : 0; end
    end
  end

  task automatic pulse_start(input int w);
    @(posedge clk); #1;
    if (w == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    chk("valid_lat1", 64'((w == 0) ? vld0 : vld1), 64'd0);
    @(posedge clk); #1;
    chk("valid_lat2", 64'((w == 0) ? vld0 : vld1), 64'd1);
  endtask

  task automatic wait_done(input int w, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if ((w == 0) ? done0 : done1) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL timeout_done: dut%0d no DONE within %0d cycles", w, budget);
    end
  endtask

  task automatic wait_word(input int w, input int index, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (w == 0 && vld0 && idx0 == 5'(index)) seen = 1;
      if (w == 1 && vld1 && idx1 == 5'(index)) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL timeout_word: dut%0d index %0d not seen within %0d cycles", w, index, budget);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++) begin
      regs[i]  = 32'(i) * 32'h1111_1111;
      mregs[i] = regs[i];
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; mode0 = 1'b0; mode1 = 1'b0;
    fill_pattern();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(vld0), 64'd0);
    chk("rst_data", 64'(dat0), 64'd0);
    chk("rst_index", 64'(idx0), 64'd0);
    chk("rst_last", 64'(last0), 64'd0);
    chk("rst_csum", 64'(csum0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_ra", 64'(ra0), 64'd0);
    chk("rst_ra_first3", 64'(ra1), 64'd3);
    chk("rst_valid_first3", 64'(vld1), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full dump with ready held high.
    push_dump(0, 0, 31);
    pulse_start(0);
    wait_done(0, 400);
    repeat (3) @(negedge clk);
    chk("q_drained_full", 64'(q0.size()), 64'd0);

    // START at word 10 and during FIN must not start another dump.
    push_dump(0, 0, 31);
    pulse_start(0);
    wait_word(0, 10, 400);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done(0, 400);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("start_in_fin_ignored", 64'(busy0), 64'd0);
    chk("q_drained_ignore", 64'(q0.size()), 64'd0);

    // Random stalls plus a register write to reg 20 while index 10 is on the output.
    mode0 = 1'b1;
    mregs[20] = 32'hDEAD_BEEF;
    push_dump(0, 0, 31);
    pulse_start(0);
    wait_word(0, 10, 400);
    regs[20] = 32'hDEAD_BEEF;
    wait_done(0, 2000);
    repeat (3) @(negedge clk);
    chk("q_drained_stall", 64'(q0.size()), 64'd0);
    mode0 = 1'b0;
    fill_pattern();

    // Asynchronous reset while index 7 is valid, then a fresh dump with regs[i]=i.
    push_dump(0, 0, 31);
    pulse_start(0);
    wait_word(0, 7, 400);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(vld0), 64'd0);
    chk("async_rst_data", 64'(dat0), 64'd0);
    chk("async_rst_index", 64'(idx0), 64'd0);
    chk("async_rst_busy", 64'(busy0), 64'd0);
    chk("async_rst_ra", 64'(ra0), 64'd0);
    q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      regs[i]  = 32'(i);
      mregs[i] = regs[i];
    end
    push_dump(0, 0, 31);
    pulse_start(0);
    wait_done(0, 400);
    repeat (3) @(negedge clk);
    chk("q_drained_restart", 64'(q0.size()), 64'd0);

    // Narrow range 3..5 with random stalls.
    fill_pattern();
    mode1 = 1'b1;
    push_dump(1, 3, 5);
    pulse_start(1);
    wait_done(1, 500);
    repeat (3) @(negedge clk);
    chk("q_drained_narrow", 64'(q1.size()), 64'd0);
    mode1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
